// File: rtl/modexp_ctrl_if.sv
// modexp_ctrl_if -- bundle of the request side and the Montgomery-multiplier
// side of the modular-exponentiation controller.
//   slave  modport : the controller's view (takes requests, drives the multiplier)
//   master modport : the requester / multiplier-model view
// Signals:
//   start, abort, base_m, one_m, exp, mod : request inputs to the controller
//   busy, done, result                    : request status / result
//   mm_start, mm_a, mm_b, mm_mod          : multiplier launch + operands
//   mm_done, mm_result                    : multiplier completion + product
//   state_dbg                             : controller FSM state (debug)
interface modexp_ctrl_if #(
  parameter int OPND_WIDTH = 2048,
  parameter int EXP_WIDTH  = 2048
);
  logic                  start;
  logic                  abort;
  logic [OPND_WIDTH-1:0] base_m;
  logic [OPND_WIDTH-1:0] one_m;
  logic [EXP_WIDTH-1:0]  exp;
  logic [OPND_WIDTH-1:0] mod;
  logic                  busy;
  logic                  done;
  logic [OPND_WIDTH-1:0] result;
  logic                  mm_start;
  logic [OPND_WIDTH-1:0] mm_a;
  logic [OPND_WIDTH-1:0] mm_b;
  logic [OPND_WIDTH-1:0] mm_mod;
  logic                  mm_done;
  logic [OPND_WIDTH-1:0] mm_result;
  logic [2:0]            state_dbg;

  modport slave (
    input  start, abort, base_m, one_m, exp, mod, mm_done, mm_result,
    output busy, done, result, mm_start, mm_a, mm_b, mm_mod, state_dbg
  );

  modport master (
    output start, abort, base_m, one_m, exp, mod, mm_done, mm_result,
    input  busy, done, result, mm_start, mm_a, mm_b, mm_mod, state_dbg
  );
endinterface

// File: rtl/modexp_ctrl.sv
// modexp_ctrl -- left-to-right square-and-multiply controller driving an
// external Montgomery multiplier. Computes result = base_m^exp (Montgomery
// form) using one_m as the Montgomery one for exp = 0.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : modexp_ctrl_if.slave (request, status, multiplier and debug signals)
//
// Handshake: a request is offered by holding start high for a cycle; it is
// taken only when the controller is idle (busy low acts as ready), operands
// are captured on that edge and busy rises the next cycle. done is a
// one-cycle pulse with result valid in the same cycle; result then holds
// until the next accepted request. Towards the multiplier, mm_start is a
// one-cycle launch with mm_a/mm_b/mm_mod stable until the one-cycle mm_done
// pulse that returns mm_result. mm_done outside a wait state is ignored.
module modexp_ctrl #(
  parameter int OPND_WIDTH = 2048,
  parameter int EXP_WIDTH  = 2048
) (
  input  logic           clk,
  input  logic           rst,
  modexp_ctrl_if.slave   bus
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    SQR      = 3'd2,
    SQR_WAIT = 3'd3,
    MUL      = 3'd4,
    MUL_WAIT = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t                state;
  logic [OPND_WIDTH-1:0] base_r;
  logic [OPND_WIDTH-1:0] one_r;
  logic [EXP_WIDTH-1:0]  exp_r;
  logic [OPND_WIDTH-1:0] mod_r;
  logic [OPND_WIDTH-1:0] acc;
  logic [OPND_WIDTH-1:0] result_r;
  logic [IW-1:0]         idx;
  logic                  busy_r;
  logic                  done_r;
  logic                  mm_start_r;

  // Operands come straight from registers that only change on the mm_done
  // edge, so they are stable across the whole multiply.
  assign bus.mm_a      = acc;
  assign bus.mm_b      = (state == MUL || state == MUL_WAIT) ? base_r : acc;
  assign bus.mm_mod    = mod_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.mm_start  = mm_start_r;
  assign bus.state_dbg = state;

  // Registered outputs are written on the transition into the state that
  // owns them, so done/mm_start are high exactly while in DONE/SQR/MUL and
  // result is already updated in the done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_r     <= '0;
      one_r      <= '0;
      exp_r      <= '0;
      mod_r      <= '0;
      acc        <= '0;
      result_r   <= '0;
      idx        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mm_start_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      mm_start_r <= 1'b0;
      if (bus.abort && state != IDLE) begin
        // abort beats a same-cycle mm_done: the product is dropped
        state  <= IDLE;
        busy_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              base_r <= bus.base_m;
              one_r  <= bus.one_m;
              exp_r  <= bus.exp;
              mod_r  <= bus.mod;
              idx    <= IW'(EXP_WIDTH - 1);
              state  <= SCAN;
              busy_r <= 1'b1;
            end
          end
          SCAN: begin
            if (exp_r[idx]) begin
              // leading one found: accumulator starts at the base itself
              acc <= base_r;
              if (idx == '0) begin
                result_r <= base_r;
                done_r   <= 1'b1;
                state    <= DONE;
              end else begin
                idx        <= idx - IW'(1);
                mm_start_r <= 1'b1;
                state      <= SQR;
              end
            end else if (idx == '0) begin
              acc      <= one_r;
              result_r <= one_r;
              done_r   <= 1'b1;
              state    <= DONE;
            end else begin
              idx <= idx - IW'(1);
            end
          end
          SQR: state <= SQR_WAIT;
          SQR_WAIT: begin
            if (bus.mm_done) begin
              acc <= bus.mm_result;
              if (exp_r[idx]) begin
                mm_start_r <= 1'b1;
                state      <= MUL;
              end else if (idx == '0) begin
                result_r <= bus.mm_result;
                done_r   <= 1'b1;
                state    <= DONE;
              end else begin
                idx        <= idx - IW'(1);
                mm_start_r <= 1'b1;
                state      <= SQR;
              end
            end
          end
          MUL: state <= MUL_WAIT;
          MUL_WAIT: begin
            if (bus.mm_done) begin
              acc <= bus.mm_result;
              if (idx == '0) begin
                result_r <= bus.mm_result;
                done_r   <= 1'b1;
                state    <= DONE;
              end else begin
                idx        <= idx - IW'(1);
                mm_start_r <= 1'b1;
                state      <= SQR;
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter OPND_WIDTH, default 2048, width of base, one_m, mod, multiplier operands and result.
REQ-002 Parameter EXP_WIDTH, default 2048, width of the exponent.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new exponentiation; accepted only in IDLE.
REQ-006 abort  input  1  cancel operation in progress; return to IDLE without done.
REQ-007 base_m  input  OPND_WIDTH  base, already in Montgomery form; sampled on accept.
REQ-008 one_m  input  OPND_WIDTH  R mod N (Montgomery one); sampled on accept.
REQ-009 exp  input  EXP_WIDTH  exponent; sampled on accept.
REQ-010 mod  input  OPND_WIDTH  modulus; sampled on accept.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-013 result  output  OPND_WIDTH  base_m^exp in Montgomery form; held until next accept.
REQ-014 mm_start  output  1  one-cycle pulse launching one Montgomery multiply.
REQ-015 mm_a, mm_b, mm_mod  output  OPND_WIDTH each  multiplier operands.
REQ-016 mm_done  input  1  one-cycle pulse from multiplier; mm_result valid with it.
REQ-017 mm_result  input  OPND_WIDTH  multiplier product.

Function
REQ-018 States SHALL be IDLE, SCAN, SQR, SQR_WAIT, MUL, MUL_WAIT, DONE.
REQ-019 IDLE: start=1 -> register base_m, one_m, exp, mod; idx <= EXP_WIDTH-1; next SCAN; busy rises next cycle.
REQ-020 SCAN (one bit per cycle, leading-zero skip): exp_r[idx]=1 -> acc <= base_r; then idx=0 -> DONE, else idx <= idx-1, -> SQR.
REQ-021 SCAN: exp_r[idx]=0 and idx=0 -> acc <= one_r, -> DONE (exp=0 gives one_m, zero multiplies); else idx <= idx-1, stay.
REQ-022 SQR: mm_start=1 for exactly one cycle with mm_a=mm_b=acc; -> SQR_WAIT.
REQ-023 SQR_WAIT: on mm_done, acc <= mm_result; exp_r[idx]=1 -> MUL; else idx=0 -> DONE, else idx <= idx-1, -> SQR.
REQ-024 MUL: mm_start=1 for one cycle with mm_a=acc, mm_b=base_r; -> MUL_WAIT.
REQ-025 MUL_WAIT: on mm_done, acc <= mm_result; idx=0 -> DONE, else idx <= idx-1, -> SQR.
REQ-026 DONE: done=1, result <= acc visible in same cycle; -> IDLE next cycle.
REQ-027 mm_a, mm_b, mm_mod SHALL stay stable from the mm_start cycle through the mm_done cycle.
REQ-028 mm_mod SHALL equal mod_r whenever busy.
REQ-029 mm_done outside SQR_WAIT/MUL_WAIT SHALL be ignored.
REQ-030 start while busy SHALL be ignored; registered operands unchanged.
REQ-031 Multiply count for exp with MSB at position p and popcount k SHALL be exactly p squarings plus k-1 multiplies.
REQ-032 abort=1 in any non-IDLE state -> IDLE next cycle; no done; result unchanged.
REQ-033 abort has priority over mm_done in the same cycle; a later stray mm_done is ignored per REQ-029.
REQ-034 abort and start in the same IDLE cycle -> start accepted.

Reset
REQ-035 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, mm_start=0, result=0, acc=0, idx=0.
REQ-036 Reset mid-operation SHALL discard all work; no done pulse after reset release.

Verification (EXP_WIDTH=8, OPND_WIDTH=16, behavioral multiplier with 3-cycle latency)
REQ-037 exp=8'h0B -> 5 SCAN cycles, then mm_start sequence S,S,M,S,M (5 pulses), done once, result=model(base^11).
REQ-038 exp=8'h00 -> 8 SCAN cycles, zero mm_start pulses, done with result=one_m.
REQ-039 exp=8'h01 -> 8 SCAN cycles, zero mm_start pulses, done with result=base_m; exp=8'h80 -> 7 squarings, 0 multiplies.
REQ-040 start pulsed during SQR_WAIT with different operands -> ignored; result matches first request.
REQ-041 abort asserted in MUL_WAIT on the mm_done cycle -> IDLE next cycle, no done; new start then completes correctly.
REQ-042 rst asserted during SQR_WAIT -> all outputs 0 immediately; stray mm_done after release -> no state change.
